seq_serializer: RTL and testbench

SEQ_SERIALIZER -- requirements
Module: seq_serializer

---
 rtl/seq_pkg.sv | 12 +
 rtl/seq_serializer_if.sv | 33 +++
 rtl/seq_fifo.sv | 48 ++++
 rtl/seq_serializer.sv | 104 ++++++++++
 tb/tb_seq_serializer.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and default sizing for the word-to-bit serializer.
package seq_pkg;

    localparam int unsigned DefWidth = 8;
    localparam int unsigned DefDepth = 4;

    typedef enum logic [0:0] {
        StIdle,
        StShift
    } seq_state_e;

endpackage

// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between a word producer and the serializer.
interface seq_serializer_if #(
    parameter int unsigned WIDTH = seq_pkg::DefWidth,
    parameter int unsigned DEPTH = seq_pkg::DefDepth
);
    logic [WIDTH-1:0]             word_in;
    logic                         word_valid;
    logic                         word_ready;
    logic                         bit_out;
    logic                         bit_valid;
    logic                         busy;
    logic [$clog2(DEPTH+1)-1:0]   fifo_level;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready,
        input  bit_out,
        input  bit_valid,
        input  busy,
        input  fifo_level
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready,
        output bit_out,
        output bit_valid,
        output busy,
        output fifo_level
    );
endinterface

// File: rtl/seq_fifo.sv
// Synchronous word FIFO; pointers carry one extra wrap bit so full and empty differ.
module seq_fifo import seq_pkg::*; #(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PW   = AW + 1;
    localparam int unsigned LvlW = $clog2(DEPTH + 1);
    localparam logic [AW:0] PtrOne = PW'(1);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             wr_en, rd_en;

    // A push while full is refused even if a pop happens on the same edge.
    assign wr_en = push & ~full & ~rst;
    assign rd_en = pop & ~empty & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + PtrOne;
            if (rd_en) rptr_q <= rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rptr_q[AW-1:0]];
    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign level = LvlW'(wptr_q - rptr_q);

endmodule

// File: rtl/seq_serializer.sv
// Queues parallel words and shifts them out MSB first, one registered bit per cycle,
// reloading from the FIFO on the last bit so consecutive words stream without a gap.
module seq_serializer import seq_pkg::*; #(
    parameter int unsigned WIDTH = DefWidth,
    parameter int unsigned DEPTH = DefDepth
) (
    input  logic             clk,
    input  logic             rst,
    seq_serializer_if.slave  bus
);
    localparam int unsigned IdxW = $clog2(WIDTH);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(WIDTH - 1);
    localparam logic [IdxW-1:0] IdxOne  = IdxW'(1);

    seq_state_e       state_q, state_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             bit_out_q, bit_out_d;
    logic             bit_valid_q, bit_valid_d;
    logic             busy_q, busy_d;

    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_rdata;

    seq_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.word_valid),
        .wdata (bus.word_in),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (bus.fifo_level)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        shreg_d     = shreg_q;
        bit_out_d   = 1'b0;
        bit_valid_d = 1'b0;
        fifo_pop    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_rdata;
                    idx_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                bit_out_d   = shreg_q[WIDTH-1];
                bit_valid_d = 1'b1;
                if (idx_q == IdxLast) begin
                    idx_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shreg_d  = fifo_rdata;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    idx_d   = idx_q + IdxOne;
                    shreg_d = shreg_q << 1;
                end
            end
            default: state_d = StIdle;
        endcase

        busy_d = (state_d == StShift);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            shreg_q     <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            shreg_q     <= shreg_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.word_ready = ~fifo_full;
    assign bus.bit_out    = bit_out_q;
    assign bus.bit_valid  = bit_valid_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_seq_serializer.sv
// Checks seq_serializer against a queue-based model of words waiting and bits in flight.
module tb_seq_serializer;
    localparam int unsigned W = 8;
    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seq_serializer_if #(.WIDTH(W), .DEPTH(D)) bus ();

    seq_serializer #(
        .WIDTH (W),
        .DEPTH (D)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_tests  = 0;
    int n_failed = 0;
    int cycles   = 0;

    // Model: words waiting in the FIFO, bits of the word currently being shifted.
    logic [W-1:0] m_words [$];
    bit           m_cur [$];
    bit           m_shifting = 0;
    bit           m_bit = 0;
    bit           m_valid = 0;
    bit           m_acc = 0;

    // Observed serial stream for directed checks.
    bit           got_bits [$];
    int           got_cyc [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycles);
        end
    endtask

    task automatic model_load();
        logic [W-1:0] w;
        w = m_words.pop_front();
        for (int i = W - 1; i >= 0; i--) m_cur.push_back(w[i]);
        m_shifting = 1;
    endtask

    task automatic model_edge(input bit r, input bit v, input logic [W-1:0] d);
        m_acc = 0;
        m_bit = 0;
        m_valid = 0;
        if (r) begin
            m_words.delete();
            m_cur.delete();
            m_shifting = 0;
            return;
        end
        m_acc = v && (m_words.size() < D);
        if (!m_shifting) begin
            if (m_words.size() > 0) model_load();
        end else begin
            m_bit = m_cur.pop_front();
            m_valid = 1;
            if (m_cur.size() == 0) begin
                if (m_words.size() > 0) model_load();
                else m_shifting = 0;
            end
        end
        if (m_acc) m_words.push_back(d);
    endtask

    task automatic step(input bit r, input bit v, input logic [W-1:0] d);
        rst = r;
        bus.word_valid = v;
        bus.word_in = d;
        @(posedge clk);
        model_edge(r, v, d);
        @(negedge clk);
        cycles++;
        check_eq("bit_valid", bus.bit_valid, m_valid);
        check_eq("bit_out", bus.bit_out, m_bit);
        check_eq("busy", bus.busy, m_shifting);
        check_eq("fifo_level", bus.fifo_level, m_words.size());
        check_eq("word_ready", bus.word_ready, m_words.size() < D);
        if (bus.bit_valid) begin
            got_bits.push_back(bus.bit_out);
            got_cyc.push_back(cycles);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0);
    endtask

    function automatic logic [W-1:0] got_word(input int idx);
        logic [W-1:0] w = '0;
        for (int i = 0; i < W; i++) w = {w[W-2:0], got_bits[idx*W+i]};
        return w;
    endfunction

    function automatic int got_span();
        if (got_cyc.size() == 0) return 0;
        return got_cyc[got_cyc.size()-1] - got_cyc[0] + 1;
    endfunction

    task automatic clear_got();
        got_bits.delete();
        got_cyc.delete();
    endtask

    logic [W-1:0] full_words [6] = '{8'h11, 8'h22, 8'h93, 8'hC4, 8'h5E, 8'hF6};

    initial begin
        int k;
        int acc_cyc;
        bit saw_full;
        bus.word_valid = 0;
        bus.word_in = '0;

        // Reset, with word_valid high to show it is ignored.
        step(1, 1, 8'hAA);
        step(1, 1, 8'hAA);
        check_eq("rst_ready", bus.word_ready, 1);
        check_eq("rst_level", bus.fifo_level, 0);

        // Single word: first bit two edges after acceptance.
        clear_got();
        step(0, 1, 8'b0011_0101);
        acc_cyc = cycles;
        idle(12);
        check_eq("single_count", got_bits.size(), 8);
        if (got_bits.size() == 8) check_eq("single_word", got_word(0), 8'h35);
        if (got_cyc.size() > 0) check_eq("single_latency", got_cyc[0] - acc_cyc, 2);
        check_eq("single_busy_after", bus.busy, 0);

        // Back-to-back words stream with no gap.
        clear_got();
        step(0, 1, 8'hA5);
        step(0, 1, 8'h3C);
        idle(22);
        check_eq("b2b_count", got_bits.size(), 16);
        check_eq("b2b_span", got_span(), 16);
        if (got_bits.size() == 16) begin
            check_eq("b2b_w0", got_word(0), 8'hA5);
            check_eq("b2b_w1", got_word(1), 8'h3C);
        end

        // Full FIFO: hold valid until all six words are taken.
        clear_got();
        k = 0;
        saw_full = 0;
        for (int n = 0; n < 200 && k < 6; n++) begin
            step(0, 1, full_words[k]);
            if (m_acc) k++;
            if (bus.fifo_level == 3'(D) && !bus.word_ready) saw_full = 1;
        end
        check_eq("full_accepted", k, 6);
        check_eq("full_seen", saw_full, 1);
        idle(60);
        check_eq("full_count", got_bits.size(), 48);
        check_eq("full_span", got_span(), 48);
        if (got_bits.size() == 48)
            for (int i = 0; i < 6; i++) check_eq("full_order", got_word(i), full_words[i]);

        // Reset in the middle of a word with two more queued.
        clear_got();
        step(0, 1, 8'hFF);
        step(0, 1, 8'h12);
        step(0, 1, 8'h34);
        for (int n = 0; n < 20 && got_bits.size() < 3; n++) step(0, 0, '0);
        check_eq("midrst_bits_before", got_bits.size(), 3);
        step(1, 0, '0);
        check_eq("midrst_valid", bus.bit_valid, 0);
        check_eq("midrst_level", bus.fifo_level, 0);
        clear_got();
        idle(20);
        check_eq("midrst_silent", got_bits.size(), 0);

        // Push on the edge that completes the last bit, with one word queued.
        clear_got();
        step(0, 1, 8'hA1);
        step(0, 0, '0);
        step(0, 1, 8'hB2);
        for (int n = 0; n < 20 && !(m_shifting && m_cur.size() == 1 && m_words.size() == 1); n++)
            step(0, 0, '0);
        step(0, 1, 8'hC3);
        check_eq("pushpop_level", bus.fifo_level, 1);
        idle(30);
        check_eq("pushpop_count", got_bits.size(), 24);
        check_eq("pushpop_span", got_span(), 24);
        if (got_bits.size() == 24) check_eq("pushpop_w2", got_word(2), 8'hC3);

        // Alternating pattern as fed to the downstream detector.
        clear_got();
        step(0, 1, 8'b0101_0101);
        idle(12);
        check_eq("e2e_count", got_bits.size(), 8);
        if (got_bits.size() == 8) check_eq("e2e_word", got_word(0), 8'h55);

        // Random traffic with occasional resets.
        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end
        idle(60);
        check_eq("final_idle_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
